// File: rtl/inst_queue.sv
// Instruction queue between IF and ID.
// An in-order circular buffer of fetched packets. It lets IF run ahead of
// ID stalls, and it breaks the combinational id_allowin -> IF request path:
// iq_allowin depends only on registered occupancy. A front-end redirect
// empties the queue in a single cycle.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int BUS_W = 98
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       if_iq_valid,
    input  logic [BUS_W-1:0]           if_iq_bus,
    output logic                       iq_allowin,
    output logic                       iq_id_valid,
    output logic [BUS_W-1:0]           iq_id_bus,
    input  logic                       id_allowin,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [BUS_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    // Handshakes and head read. Full is judged from registered state only,
    // so a same-cycle pop never lets a push into a full queue.
    always_comb begin
        iq_allowin  = (count_q != FULL_COUNT);
        iq_id_valid = (count_q != '0) & ~flush;
        iq_id_bus   = mem_q[rd_ptr_q];
        iq_count    = count_q;
        push        = if_iq_valid & iq_allowin & ~flush;
        pop         = iq_id_valid & id_allowin;
    end

    // Next pointer and occupancy values; a redirect discards every entry.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= if_iq_bus;
        end
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the IF and ID stages of the LoongArch pipeline. Buffers up to DEPTH fetched instruction packets in order. This decouples instruction-SRAM return timing from ID back-pressure, and cuts the combinational `id_allowin` → IF request path. The queue is discarded in one cycle on any front-end redirect (exception, ertn, branch, TLB refetch).

## Interface
- `DEPTH`, 4: number of entries; a power of two, ≥ 2.
- `BUS_W`, 98: packet width, {adef[97], wrong_addr[96:65], pc[64:33], inst[32:1], tlb_zombie[0]}; the packet is carried opaquely.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: redirect; OR of wb_ex, ertn_flush, branch taken and tlb_reflush, supplied by the top level.
- `if_iq_valid` input 1: IF presents a packet.
- `if_iq_bus` input BUS_W: the packet from IF.
- `iq_allowin` output 1: the queue accepts a packet this cycle; fed to IF in place of `id_allowin`.
- `iq_id_valid` output 1: the head packet is valid for ID.
- `iq_id_bus` output BUS_W: the head packet.
- `id_allowin` input 1: ID consumes the head this cycle.
- `iq_count` output $clog2(DEPTH)+1: current occupancy, for performance counters and debug.

## Operation
- Storage: an entry array `mem[DEPTH]`, read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and `count` (0..DEPTH).
- `iq_allowin = (count != DEPTH)`. It depends only on registered state, never on `id_allowin` or `flush`.
- push = `if_iq_valid & iq_allowin & ~flush`. On push: `mem[wr_ptr] <= if_iq_bus` and `wr_ptr <= wr_ptr+1`.
- `iq_id_valid = (count != 0) & ~flush`.
- `iq_id_bus = mem[rd_ptr]`, combinational read. Its value is don't-care when `iq_id_valid` = 0.
- pop = `iq_id_valid & id_allowin`. On pop: `rd_ptr <= rd_ptr+1`.
- Count update: `count <= count + push - pop`, using width-safe arithmetic with no underflow or overflow.
  - push and pop in the same cycle leaves `count` unchanged and advances both pointers.
- Full: a push is refused even if a pop happens in the same cycle; there is no full pass-through. IF holds its packet and retries on the next cycle.
- Empty: there is no bypass. A packet pushed at cycle N is first visible to ID at N+1.
- Flush takes priority over everything:
  - On the next edge `rd_ptr`, `wr_ptr` and `count` are cleared to 0.
  - In the flush cycle the push is dropped, and `iq_id_valid` is 0, so ID consumes nothing.
  - Array contents are not cleared.
- Reset behaves like flush and additionally overrides it.
- Packets with adef=1 or tlb_zombie=1 are queued and delivered unchanged. Exception handling belongs to ID/EX.
- There is no state machine beyond the pointer and count registers.

## Timing
- Reset values: `iq_allowin`=1, `iq_id_valid`=0, `iq_count`=0, `rd_ptr`=`wr_ptr`=0.
  - `iq_id_bus` is undefined after reset; `mem` is not reset.
- Latency through an empty queue is exactly 1 cycle.
- Throughput is 1 packet per cycle while 0 < count < DEPTH.
- `iq_allowin` falls in the cycle after the DEPTH-th push with no pop.
  - It rises in the cycle after the first pop from full.
- Flush at cycle N: `iq_id_valid`=0 at N, `iq_count`=0 and `iq_allowin`=1 at N+1, and a new push is accepted at N+1.
- Reset asserted mid-operation: all registers are cleared on the next edge, regardless of in-flight push or pop.
- `iq_count` is registered and always equals `count`.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `if_iq_valid`=1 → `iq_id_valid`=0, `iq_allowin`=1, `iq_count`=0. Nothing is stored.
- Fill and back-pressure:
  - Stimulus: `id_allowin`=0; push pcs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c on consecutive cycles.
  - Response: `iq_count` = 1, 2, 3, 4 after each edge; `iq_allowin`=0 after the 4th push. A 5th packet presented is not accepted until a pop.
- Drain order and wrap:
  - Stimulus: from full, `id_allowin`=1 with a continuous push stream 0x1c000010 onward.
  - Response: pcs delivered in strict order 0x1c000000, 0x1c000004, …. `iq_count` stays 4 while pushes are blocked, then settles at 3 under steady push+pop. Pointers wrap past index 3 with no reordering.
- Flush mid-queue:
  - Stimulus: `count`=3; assert `flush` together with `if_iq_valid`=1 and `id_allowin`=1.
  - Response: `iq_id_valid`=0 in the flush cycle, `iq_count`=0 next cycle, and the pushed packet is discarded. The next pushed pc (0x1c008000) appears at the head one cycle after its push.
- Exception packet: push a packet with adef=1 and wrong_addr=0x1c000002 → it is delivered with all 98 bits identical.
- Reset mid-stream: assert `reset` for 1 cycle with `count`=2 and push+pop active → `iq_count`=0 and `iq_id_valid`=0 the next cycle. Afterwards the first pushed packet is delivered correctly.
